instr_mem_loader: RTL and testbench
===================================

Name: instr_mem_loader

Overview:
- Byte-stream programmer that fills the instruction memory before or between program runs.
- Receives a framed byte stream over a valid/ready handshake: 16-bit word count, instruction bytes, XOR checksum.
- Issues single-byte writes to the instruction memory's write port, big-endian per word, so the fetch side assembles words correctly.
- Holds the CPU in stall for the whole duration of a load.

Parameters:
PCSize, 32, width of the memory byte address (matches fetch PC width)
AmountOfInstructions, 128, memory depth in bytes; loads whose length exceeds it are rejected

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
start  input  1  one-cycle pulse that begins a load; honoured only in IDLE or DONE
in_valid  input  1  source has a byte on in_data
in_data  input  8  stream byte
in_ready  output  1  loader accepts in_data this cycle; transfer when in_valid & in_ready
mem_we  output  1  byte write strobe to instruction memory
mem_addr  output  PCSize  byte address of write
mem_wdata  output  8  byte to write
cpu_hold  output  1  stall request to CPU/PC while loading
busy  output  1  load in progress
done  output  1  last load finished (ok or error); sticky until next start
error  output  1  last load failed; sticky until next start
words_loaded  output  16  count of complete 4-byte words written in current/last load

Behaviour:
- Reset (rst=1 at clk edge): state IDLE; in_ready, mem_we, cpu_hold, busy, done, error = 0; mem_addr, mem_wdata, words_loaded, byte counter, checksum, length = 0. Reset mid-load aborts immediately; no further mem_we; already-written bytes stay in memory.
- States: IDLE, LEN_HI, LEN_LO, DATA, CHECK, DONE.
- IDLE/DONE: in_ready=0, busy=cpu_hold=0. On start, go to LEN_HI; clear done, error, words_loaded, byte counter, checksum. start in any other state is ignored.
- LEN_HI: in_ready=1; on transfer, len[15:8]=in_data, go to LEN_LO.
- LEN_LO: in_ready=1; on transfer, len[7:0]=in_data.
  - If len==0, go to CHECK.
  - Else if 4*len > AmountOfInstructions (compute in 18 bits, no overflow), go to DONE with error=1 and done=1. No memory writes occur.
  - Else go to DATA.
- DATA: in_ready=1, one byte per cycle max.
  - Each transfer at byte index i (0..4*len-1) produces, on the next cycle, mem_we=1 for exactly one cycle with mem_addr=i and mem_wdata=byte.
  - Bytes are written in arrival order. Word k occupies addresses 4k..4k+3; the first byte of each word is the MSB (instruction bits 31:24), the last is bits 7:0.
  - checksum ^= byte on each transfer.
  - words_loaded increments when the 4th byte of a word is transferred.
  - After transfer of byte 4*len-1, go to CHECK.
- CHECK: in_ready=1; on transfer, compare in_data with checksum (the XOR of data bytes only; length bytes excluded). Go to DONE with done=1; set error=1 on mismatch.
- busy = cpu_hold = 1 in LEN_HI, LEN_LO, DATA and CHECK. Both deassert in the same cycle done rises. The final data write (one cycle after last transfer) always completes before done, since CHECK needs at least one more transfer.
- in_valid=0 cycles (gaps) stall progress with no state change. in_data is ignored when in_ready=0.
- mem_we=0 in every cycle without a pending write. mem_addr/mem_wdata hold their last values otherwise.

Test Plan:
- Good load: start; stream 00 01 12 34 56 78 08 -> writes (addr,data) = (0,12),(1,34),(2,56),(3,78), one per cycle; words_loaded=1; done=1, error=0; cpu_hold high from cycle after start until done.
- Bad checksum: same stream with final byte 09 -> identical 4 writes; done=1, error=1.
- Empty load: 00 00 00 -> zero mem_we pulses, done=1, error=0. Oversize: 00 21 (33 words, 132>128) -> done=1, error=1 right after second byte, in_ready drops, no writes.
- Backpressure/gaps: good load with in_valid toggling 1,0,0,1… -> writes only after real transfers, addresses 0..3 contiguous, same final result; start pulse during DATA ignored.
- Reset mid-load: assert rst after 2 data bytes -> next cycle all outputs 0, state IDLE, no further mem_we; new start plus full good stream then succeeds from addr 0.
- Max load: len=0x0020 (128 bytes), bytes = address index, checksum = XOR 0..127 = 00 -> last write addr 127 data 7F, words_loaded=32, error=0.

Source files
------------

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: byte-stream programmer for the instruction memory.
// Accepts a framed stream (16-bit word count, big-endian instruction bytes,
// XOR checksum) over valid/ready and writes each byte, one cycle after it
// arrives, to the instruction memory's byte write port. The CPU is held in
// stall while a load is in progress.
module instr_mem_loader #(
    parameter int PCSize               = 32,
    parameter int AmountOfInstructions = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [PCSize-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [15:0]       words_loaded
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LEN_HI = 3'd1;
    localparam logic [2:0] S_LEN_LO = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_CHECK  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    // Memory capacity in bytes, widened so 4*len (up to 18 bits) compares cleanly.
    localparam logic [17:0] MaxBytes = 18'(AmountOfInstructions);

    logic [2:0]  state;
    logic [15:0] len;
    logic [17:0] byte_cnt;
    logic [7:0]  checksum;

    logic        active;
    logic        xfer;
    logic [15:0] len_full;
    logic [17:0] len_bytes;
    logic [17:0] last_idx;

    // Byte count of the load as it will be once the low length byte lands.
    function automatic logic [17:0] bytes_of(input logic [15:0] words);
        return {words, 2'b00};
    endfunction

    // Length exceeding memory capacity is rejected before any write happens.
    function automatic logic too_long(input logic [15:0] words);
        return bytes_of(words) > MaxBytes;
    endfunction

    assign len_full  = {len[15:8], in_data};
    assign len_bytes = bytes_of(len);
    assign last_idx  = len_bytes - 18'd1;

    // Handshake and stall outputs follow directly from the current state.
    always_comb begin
        active   = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                   (state == S_DATA)   || (state == S_CHECK);
        in_ready = active;
        busy     = active;
        cpu_hold = active;
        xfer     = active && in_valid;
    end

    // Load sequencer: frame parsing, memory write issue, checksum and status.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            len          <= 16'd0;
            byte_cnt     <= 18'd0;
            checksum     <= 8'd0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= 8'd0;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= 16'd0;
        end else begin
            // The write strobe is a single-cycle pulse per accepted data byte.
            mem_we <= 1'b0;

            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state        <= S_LEN_HI;
                        done         <= 1'b0;
                        error        <= 1'b0;
                        words_loaded <= 16'd0;
                        byte_cnt     <= 18'd0;
                        checksum     <= 8'd0;
                    end
                end

                S_LEN_HI: begin
                    if (xfer) begin
                        len[15:8] <= in_data;
                        state     <= S_LEN_LO;
                    end
                end

                S_LEN_LO: begin
                    if (xfer) begin
                        len[7:0] <= in_data;
                        if (len_full == 16'd0) begin
                            state <= S_CHECK;
                        end else if (too_long(len_full)) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            error <= 1'b1;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end

                S_DATA: begin
                    if (xfer) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= PCSize'(byte_cnt);
                        mem_wdata <= in_data;
                        checksum  <= checksum ^ in_data;
                        byte_cnt  <= byte_cnt + 18'd1;
                        // Fourth byte of a word completes that word.
                        if (byte_cnt[1:0] == 2'b11) begin
                            words_loaded <= words_loaded + 16'd1;
                        end
                        if (byte_cnt == last_idx) begin
                            state <= S_CHECK;
                        end
                    end
                end

                S_CHECK: begin
                    if (xfer) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        error <= (in_data != checksum);
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: a stream-level model predicts the
// memory writes and final status of each load; a monitor checks every write.
module tb_instr_mem_loader;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;

    int checks = 0;
    int errors = 0;

    wr_t        exp_q[$];
    logic [7:0] data_q[$];

    instr_mem_loader #(.PCSize(32), .AmountOfInstructions(128)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest predicted write.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                         mem_addr, mem_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (mem_addr !== e.addr || mem_wdata !== e.data || cpu_hold !== 1'b1) begin
                    errors++;
                    $display("FAIL write: got addr %0h data %0h hold %0b expected addr %0h data %0h hold 1",
                             mem_addr, mem_wdata, cpu_hold, e.addr, e.data);
                end
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offers one byte after some idle cycles; returns once it is transferred.
    task automatic send_byte(input logic [7:0] b, input int gaps);
        int n;
        for (int g = 0; g < gaps; g++) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = 8'($urandom);
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got in_ready %0b expected 1", in_ready);
        end
    endtask

    function automatic int pick_gap(input int max_gap, input bit fixed);
        if (fixed) return max_gap;
        return int'($urandom_range(0, max_gap));
    endfunction

    // Runs one load of len words using data_q as payload; cmask != 0 corrupts
    // the checksum byte; start_at >= 0 pulses start after that data byte.
    task automatic run_load(input string tag, input logic [15:0] len, input int max_gap,
                            input bit fixed, input logic [7:0] cmask, input int start_at);
        int         total;
        bit         over;
        logic [7:0] chk;
        int         n;
        bit         exp_err;
        total = 4 * int'(len);
        over  = total > 128;
        chk   = 8'h00;
        if (!over) begin
            for (int i = 0; i < total; i++) begin
                exp_q.push_back('{addr: 32'(i), data: data_q[i]});
                chk ^= data_q[i];
            end
        end
        exp_err = over || (cmask != 8'h00);

        pulse_start();
        check({tag, "_hold_after_start"}, {31'd0, cpu_hold}, 32'd1);
        check({tag, "_busy_after_start"}, {31'd0, busy}, 32'd1);

        send_byte(len[15:8], pick_gap(max_gap, fixed));
        send_byte(len[7:0], pick_gap(max_gap, fixed));
        if (!over) begin
            for (int i = 0; i < total; i++) begin
                send_byte(data_q[i], pick_gap(max_gap, fixed));
                if (i == start_at) begin
                    @(negedge clk);
                    in_valid = 1'b0;
                    start    = 1'b1;
                    @(negedge clk);
                    start    = 1'b0;
                end
            end
            send_byte(chk ^ cmask, pick_gap(max_gap, fixed));
        end
        @(negedge clk);
        in_valid = 1'b0;

        n = 0;
        while (done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_error"}, {31'd0, error}, {31'd0, exp_err});
        check({tag, "_words"}, {16'd0, words_loaded}, over ? 32'd0 : 32'(len));
        check({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
        check({tag, "_hold_end"}, {31'd0, cpu_hold}, 32'd0);
        check({tag, "_ready_end"}, {31'd0, in_ready}, 32'd0);
        check({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
        check({tag, "_mem_addr"}, mem_addr, 32'd0);
        check({tag, "_mem_wdata"}, {24'd0, mem_wdata}, 32'd0);
        check({tag, "_words"}, {16'd0, words_loaded}, 32'd0);
        check({tag, "_ready"}, {31'd0, in_ready}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_hold"}, {31'd0, cpu_hold}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_error"}, {31'd0, error}, 32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;

        // Good load: one word 12345678, checksum 08.
        data_q = '{8'h12, 8'h34, 8'h56, 8'h78};
        run_load("good", 16'h0001, 0, 1'b1, 8'h00, -1);

        // Same stream with checksum 09.
        run_load("badsum", 16'h0001, 0, 1'b1, 8'h01, -1);

        // Empty and oversize loads.
        run_load("empty", 16'h0000, 0, 1'b1, 8'h00, -1);
        run_load("oversize", 16'h0021, 0, 1'b1, 8'h00, -1);

        // Gapped stream with a stray start pulse during DATA.
        run_load("gaps", 16'h0001, 2, 1'b1, 8'h00, 1);

        // Reset after two data bytes.
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        exp_q.push_back('{addr: 32'd0, data: 8'h12});
        exp_q.push_back('{addr: 32'd1, data: 8'h34});
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check_idle_outputs("midreset");
        check("midreset_pending_writes", 32'(exp_q.size()), 32'd0);
        rst = 1'b0;
        exp_q.delete();
        run_load("after_reset", 16'h0001, 0, 1'b1, 8'h00, -1);

        // Full-memory load with byte = address.
        data_q.delete();
        for (int i = 0; i < 128; i++) data_q.push_back(8'(i));
        run_load("max", 16'h0020, 0, 1'b1, 8'h00, -1);

        // Randomized loads: lengths straddle the capacity limit.
        for (int t = 0; t < 25; t++) begin
            logic [15:0] l;
            logic [7:0]  m;
            l = 16'($urandom_range(0, 36));
            m = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            data_q.delete();
            for (int i = 0; i < 4 * int'(l); i++) data_q.push_back(8'($urandom));
            run_load("rand", l, 2, 1'b0, m, -1);
        end

        repeat (3) @(negedge clk);
        check("final_pending_writes", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
